// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the 6-bit LFSR generator and the
//               receive-side sequence checker: word width, seed value, the
//               next-state step function and the checker state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

  localparam int          LFSR_W    = 6;
  localparam logic [5:0]  LFSR_SEED = 6'h3F;

  // Checker state encoding.
  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } chk_state_t;

  // One step of the LFSR; every new bit is taken from the current word.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    logic [LFSR_W-1:0] n;
    n[0] = q[5];
    n[1] = q[0];
    n[2] = q[1] ^ q[5];
    n[3] = q[2];
    n[4] = q[3] ^ q[5];
    n[5] = q[4] ^ q[5];
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_checker_if
// Description : Sample/status bundle between an LFSR word source and the
//               sequence checker.
//   din       : received LFSR word (bit 5 = MSB)
//   din_vld   : din carries a valid sample this cycle
//   clr_cnt   : synchronous clear of err_cnt
//   locked    : checker is in LOCKED
//   err_pulse : previous valid sample mismatched while LOCKED
//   err_cnt   : saturating mismatch count
//   master    : word source side; slave : checker side
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_seq_checker_if
  import lfsr_pkg::*;
#(
  parameter int ERR_W = 16
) ();

  logic [LFSR_W-1:0] din;
  logic              din_vld;
  logic              clr_cnt;
  logic              locked;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;

  modport master (
    output din, din_vld, clr_cnt,
    input  locked, err_pulse, err_cnt
  );

  modport slave (
    input  din, din_vld, clr_cnt,
    output locked, err_pulse, err_cnt
  );

endinterface
`default_nettype wire

// File: rtl/lfsr_step.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_step
// Description : Combinational single step of the 6-bit LFSR.
//   q      : current word
//   q_next : successor word
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_step
  import lfsr_pkg::*;
(
  input  wire logic [LFSR_W-1:0] q,
  output logic      [LFSR_W-1:0] q_next
);

  assign q_next = lfsr_next(q);

endmodule
`default_nettype wire

// File: rtl/lfsr_seq_checker.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_seq_checker
// Description : Receive-side checker for the 6-bit LFSR word stream. In
//               SEARCH it reseeds its predictor from every received word and
//               counts consecutive correct predictions until LOCK_CNT; in
//               LOCKED the predictor free-runs and mismatches are flagged and
//               counted, with lock dropped after LOSS_CNT in a row.
//   clk   : system clock
//   rst_b : synchronous active-low reset
//   bus   : slave side of lfsr_seq_checker_if (din, din_vld, clr_cnt in;
//           locked, err_pulse, err_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_CNT = 4,
  parameter int LOSS_CNT = 3,
  parameter int ERR_W    = 16
) (
  input  wire logic          clk,
  input  wire logic          rst_b,
  lfsr_seq_checker_if.slave  bus
);

  localparam logic [3:0]       c_lock_cnt = 4'(LOCK_CNT);
  localparam logic [3:0]       c_loss_cnt = 4'(LOSS_CNT);
  localparam logic [ERR_W-1:0] c_cnt_max  = '1;
  localparam logic [ERR_W-1:0] c_cnt_one  = {{(ERR_W-1){1'b0}}, 1'b1};

  chk_state_t        r_state;
  logic [LFSR_W-1:0] r_pred;
  logic [3:0]        r_good_run;
  logic [3:0]        r_bad_run;
  logic              r_seed_vld;
  logic              r_err_pulse;
  logic [ERR_W-1:0]  r_err_cnt;

  chk_state_t        w_state_nxt;
  logic [LFSR_W-1:0] w_pred_nxt;
  logic [3:0]        w_good_nxt;
  logic [3:0]        w_bad_nxt;
  logic              w_seed_vld_nxt;
  logic              w_err_pulse_nxt;
  logic [ERR_W-1:0]  w_err_cnt_nxt;

  logic [LFSR_W-1:0] w_din_step;
  logic [LFSR_W-1:0] w_pred_step;
  logic              w_match;
  logic [3:0]        w_good_inc;
  logic [3:0]        w_bad_inc;
  logic [ERR_W-1:0]  w_cnt_base;

  // Reseed path (SEARCH) and flywheel path (LOCKED).
  lfsr_step u_step_din (
    .q      (bus.din),
    .q_next (w_din_step)
  );

  lfsr_step u_step_pred (
    .q      (r_pred),
    .q_next (w_pred_step)
  );

  // The all-zero word is the LFSR lock-up state and never matches.
  assign w_match    = (bus.din == r_pred) && (bus.din != '0);
  assign w_good_inc = r_good_run + 4'd1;
  assign w_bad_inc  = r_bad_run + 4'd1;
  // Clear is applied first so that a mismatch in the same cycle lands on 1.
  assign w_cnt_base = bus.clr_cnt ? '0 : r_err_cnt;

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      r_state     <= SEARCH;
      r_pred      <= LFSR_SEED;
      r_good_run  <= '0;
      r_bad_run   <= '0;
      r_seed_vld  <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pred      <= w_pred_nxt;
      r_good_run  <= w_good_nxt;
      r_bad_run   <= w_bad_nxt;
      r_seed_vld  <= w_seed_vld_nxt;
      r_err_pulse <= w_err_pulse_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_pred_nxt      = r_pred;
    w_good_nxt      = r_good_run;
    w_bad_nxt       = r_bad_run;
    w_seed_vld_nxt  = r_seed_vld;
    w_err_pulse_nxt = 1'b0;
    w_err_cnt_nxt   = w_cnt_base;

    if (bus.din_vld) begin
      case (r_state)
        SEARCH: begin
          w_pred_nxt = w_din_step;
          if (!r_seed_vld) begin
            // First sample only seeds the predictor.
            w_seed_vld_nxt = 1'b1;
          end else if (w_match) begin
            w_good_nxt = w_good_inc;
            if (w_good_inc == c_lock_cnt) begin
              w_state_nxt = LOCKED;
              w_bad_nxt   = '0;
            end
          end else begin
            w_good_nxt = '0;
          end
        end

        LOCKED: begin
          // Free-running predictor: a corrupt sample does not reseed.
          w_pred_nxt = w_pred_step;
          if (w_match) begin
            w_bad_nxt = '0;
          end else begin
            w_err_pulse_nxt = 1'b1;
            w_err_cnt_nxt   = (w_cnt_base == c_cnt_max) ? c_cnt_max
                                                        : w_cnt_base + c_cnt_one;
            w_bad_nxt       = w_bad_inc;
            if (w_bad_inc == c_loss_cnt) begin
              w_state_nxt    = SEARCH;
              w_good_nxt     = '0;
              w_seed_vld_nxt = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.locked    = (r_state == LOCKED);
  assign bus.err_pulse = r_err_pulse;
  assign bus.err_cnt   = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/lfsr_seq_checker.md
Name: lfsr_seq_checker

Overview:
- Consumer of the 6-bit pseudo-random word produced by the team's LFSR stage.
- Takes one sample per valid cycle and locks onto the sequence using the same next-state function as the generator.
- Once locked, flags and counts every sample that deviates from the predicted sequence, and drops lock after repeated mismatches.
- Used as the self-check at the receive side of LFSR-driven test/scrambling paths.

Parameters:
- LOCK_CNT, 4: consecutive correct predictions required to enter LOCKED (1..15).
- LOSS_CNT, 3: consecutive mismatches in LOCKED that force return to SEARCH (1..15).
- ERR_W, 16: width of the saturating error counter.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- rst_b  input  1  synchronous active-low reset.
- din  input  6  received LFSR word, bit 5 = MSB.
- din_vld  input  1  din is a valid sample this cycle; no state changes when low.
- clr_cnt  input  1  synchronous clear of err_cnt.
- locked  output  1  checker is in LOCKED state.
- err_pulse  output  1  one-cycle flag: the previous valid sample mismatched while LOCKED.
- err_cnt  output  ERR_W  saturating count of mismatches seen while LOCKED.

Behaviour:
- Reset: one clock, and reset is synchronous and active-low (clk, rst_b). While rst_b=0 at posedge, state is SEARCH, locked=0, err_pulse=0, err_cnt=0, good_run=0, bad_run=0, seed_vld=0, and the predictor register is 6'h3F.
- Next-state function f(q), identical to the generator, with each new bit taken from the current word:
  - new[0]=q[5]
  - new[1]=q[0]
  - new[2]=q[1]^q[5]
  - new[3]=q[2]
  - new[4]=q[3]^q[5]
  - new[5]=q[4]^q[5]
- Example: f(3F)=0B, f(0B)=16, f(16)=2C, f(2C)=2D, f(2D)=2F.
- All-zero word: it is the lock-up state and never counts as a match. din=00 is always treated as a mismatch.
- SEARCH state, on each din_vld=1:
  - If seed_vld=0: load pred<=f(din), set seed_vld=1, and make no comparison.
  - Otherwise, if din==pred and din!=0: good_run++. Else good_run<=0.
  - In both cases pred<=f(din), i.e. reseed from the received word.
  - When good_run reaches LOCK_CNT, move to LOCKED and clear bad_run.
- LOCKED state (flywheel), on each din_vld=1:
  - The predictor free-runs: pred<=f(pred) regardless of din, so one corrupt sample does not derail prediction.
  - Match: bad_run<=0.
  - Mismatch: err_pulse=1 in the next cycle, err_cnt++ (saturating at all-ones), bad_run++.
  - When bad_run reaches LOSS_CNT: go to SEARCH with good_run=0 and seed_vld=0. The mismatch that triggers loss is still counted.
- Output timing: locked, err_pulse and err_cnt are registered. They reflect a sample one cycle after the edge that samples it. err_pulse is 0 in every cycle not directly following a mismatching valid sample in LOCKED.
- din_vld=0: all state holds and err_pulse is 0.
- clr_cnt: if clr_cnt=1 in the same cycle as a counted mismatch, err_cnt becomes 1 (clear, then count). Otherwise clr_cnt=1 sets err_cnt to 0.
- Reset mid-operation: rst_b has priority over everything, including clr_cnt and din_vld.

Decomposition:
- Shared package lfsr_pkg:
  - LFSR_W=6
  - LFSR_SEED=6'h3F
  - the f() step as a function
  - state encoding SEARCH/LOCKED
- The generator and checker share this package.
- One combinational sub-module, lfsr_step (q in, next q out). It is instantiated twice: once for the din reseed path and once for the flywheel path.

Test Plan:
1. Lock acquisition: rst_b low 2 cycles then high; drive 3F,0B,16,2C,2D with din_vld=1 -> locked rises in the cycle after 2D is sampled; err_cnt=0.
2. Single error while locked: after test 1, drive 00 in place of the expected 2F, then 2D-successor values from the flywheel (f(2F), ...) -> one err_pulse cycle, err_cnt=1, locked stays 1, the next correct words produce no pulse.
3. Loss of lock: while locked, drive 3 consecutive wrong words (e.g. 15,15,15) -> err_cnt increments to 3, locked falls the cycle after the 3rd sample, and the checker re-locks after a fresh seed plus 4 correct words.
4. Gapped valid: repeat test 1 with din_vld=0 between every sample and din set to garbage during the gaps -> identical lock timing counted in valid samples; no err_pulse.
5. Counter control: force 65536 mismatches (ERR_W=16) with LOSS_CNT=15 and periodic matches -> err_cnt saturates at FFFF. Then assert clr_cnt together with a mismatch -> err_cnt=1.
6. Synchronous reset mid-lock: rst_b=0 for one edge while locked -> locked=0, err_cnt=0 after that edge. Check that an rst_b glitch between edges has no effect.
